// File: rtl/cam_px_source_if.sv
// Camera-side bus of cam_px_source: frame-buffer read port plus the
// DVP-style pixel outputs (pclk, vsync, href, px_data, frame_done).
interface cam_px_source_if #(
    parameter int unsigned AW = 16
);
    logic [AW-1:0] mem_px_addr;
    logic [7:0]    mem_px_data;
    logic          pclk;
    logic          vsync;
    logic          href;
    logic [7:0]    px_data;
    logic          frame_done;

    // Pixel source side
    modport master (
        output mem_px_addr,
        output pclk,
        output vsync,
        output href,
        output px_data,
        output frame_done,
        input  mem_px_data
    );

    // Frame buffer / receiver side
    modport slave (
        input  mem_px_addr,
        input  pclk,
        input  vsync,
        input  href,
        input  px_data,
        input  frame_done,
        output mem_px_data
    );
endinterface

// File: rtl/cam_px_source.sv
// cam_px_source: emulates a parallel camera sensor. Generates pclk = clk/2,
// vsync/href framing and pixel bytes read from a frame buffer.
// Optional build macro CAM_PX_SOURCE_TESTPAT_EN replaces memory pixels with
// an XOR test pattern (column ^ line); timing is identical in both builds.
module cam_px_source #(
    parameter int unsigned AW        = 16,
    parameter int unsigned H_PIX     = 160,
    parameter int unsigned V_LINES   = 120,
    parameter int unsigned VSYNC_LEN = 3,
    parameter int unsigned VBP       = 2,
    parameter int unsigned VFP       = 2,
    parameter int unsigned H_BLANK   = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    cam_px_source_if.master bus
);

    localparam int unsigned LINE_LEN = H_PIX + H_BLANK;
    localparam int unsigned HW       = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1;
    localparam int unsigned V_SUM    = V_LINES + VSYNC_LEN + VBP + VFP;
    localparam int unsigned VW       = $clog2(V_SUM + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_VSYNC,
        S_VBP,
        S_ACTIVE,
        S_HBLANK,
        S_VFP
    } state_e;

    state_e        state_q, state_d;
    logic          pclk_q, pclk_d;
    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic          vsync_q, vsync_d;
    logic          href_q, href_d;
    logic [7:0]    px_q, px_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          done_q, done_d;
    logic          line_end_c;

    // Last pixel period of the current line
    assign line_end_c = (h_q == HW'(LINE_LEN - 1));

    // State and output registers; synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            pclk_q  <= 1'b0;
            h_q     <= '0;
            v_q     <= '0;
            vsync_q <= 1'b0;
            href_q  <= 1'b0;
            px_q    <= 8'd0;
            addr_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pclk_q  <= pclk_d;
            h_q     <= h_d;
            v_q     <= v_d;
            vsync_q <= vsync_d;
            href_q  <= href_d;
            px_q    <= px_d;
            addr_q  <= addr_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic; everything but pclk advances only on ticks (pclk_q=1)
    always_comb begin
        state_d = state_q;
        pclk_d  = pclk_q;
        h_d     = h_q;
        v_d     = v_q;
        vsync_d = vsync_q;
        href_d  = href_q;
        px_d    = px_q;
        addr_d  = addr_q;
        done_d  = 1'b0;

        if (state_q == S_IDLE) begin
            pclk_d  = 1'b0;
            vsync_d = 1'b0;
            href_d  = 1'b0;
            px_d    = 8'd0;
            if (en) begin
                state_d = S_VSYNC;
                h_d     = '0;
                v_d     = '0;
                addr_d  = '0;
            end
        end else begin
            pclk_d = ~pclk_q;
            if (pclk_q) begin
                vsync_d = 1'b0;
                href_d  = 1'b0;
                px_d    = 8'd0;
                h_d     = line_end_c ? '0 : h_q + HW'(1);
                case (state_q)
                    S_VSYNC: begin
                        vsync_d = 1'b1;
                        if (line_end_c) begin
                            if (v_q == VW'(VSYNC_LEN - 1)) begin
                                state_d = S_VBP;
                                v_d     = '0;
                            end else begin
                                v_d = v_q + VW'(1);
                            end
                        end
                    end
                    S_VBP: begin
                        if (line_end_c) begin
                            if (v_q == VW'(VBP - 1)) begin
                                state_d = S_ACTIVE;
                                v_d     = '0;
                            end else begin
                                v_d = v_q + VW'(1);
                            end
                        end
                    end
                    S_ACTIVE: begin
                        href_d = 1'b1;
`ifdef CAM_PX_SOURCE_TESTPAT_EN
                        px_d   = 8'(h_q) ^ 8'(v_q);
`else
                        px_d   = bus.mem_px_data;
                        addr_d = addr_q + AW'(1);
`endif
                        if (h_q == HW'(H_PIX - 1)) begin
                            state_d = S_HBLANK;
                        end
                    end
                    S_HBLANK: begin
                        if (line_end_c) begin
                            if (v_q == VW'(V_LINES - 1)) begin
                                state_d = S_VFP;
                                v_d     = '0;
                            end else begin
                                state_d = S_ACTIVE;
                                v_d     = v_q + VW'(1);
                            end
                        end
                    end
                    S_VFP: begin
                        if (line_end_c) begin
                            if (v_q == VW'(VFP - 1)) begin
                                done_d = 1'b1;
                                v_d    = '0;
                                if (en) begin
                                    state_d = S_VSYNC;
                                    addr_d  = '0;
                                end else begin
                                    state_d = S_IDLE;
                                end
                            end else begin
                                v_d = v_q + VW'(1);
                            end
                        end
                    end
                    default: state_d = S_IDLE;
                endcase
            end
        end
    end

    // Registered outputs onto the bus
    assign bus.mem_px_addr = addr_q;
    assign bus.pclk        = pclk_q;
    assign bus.vsync       = vsync_q;
    assign bus.href        = href_q;
    assign bus.px_data     = px_q;
    assign bus.frame_done  = done_q;

endmodule

// File: tb/tb_cam_px_source.sv
// Directed bench for cam_px_source using a reduced frame geometry:
// 8 active + 4 blank pixels per line, vsync 2 lines, VBP 1, 5 active lines,
// VFP 2 -> 120 ticks (240 clk) per frame. AW=4 so the address wraps mid-frame.
module tb_cam_px_source;

    localparam int unsigned AW        = 4;
    localparam int unsigned H_PIX     = 8;
    localparam int unsigned H_BLANK   = 4;
    localparam int unsigned V_LINES   = 5;
    localparam int unsigned VSYNC_LEN = 2;
    localparam int unsigned VBP       = 1;
    localparam int unsigned VFP       = 2;

    localparam int LINE    = 12;
    localparam int VS_END  = 24;
    localparam int BP_END  = 36;
    localparam int ACT_END = 96;
    localparam int FRAME_T = 120;
    localparam int ADDR_MOD = 16;

`ifdef CAM_PX_SOURCE_TESTPAT_EN
    localparam bit TP = 1'b1;
`else
    localparam bit TP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic en;
    int   checks = 0;
    int   errors = 0;
    int   hp;
    int   vt;

    cam_px_source_if #(.AW(AW)) bus ();

    cam_px_source #(
        .AW(AW), .H_PIX(H_PIX), .V_LINES(V_LINES), .VSYNC_LEN(VSYNC_LEN),
        .VBP(VBP), .VFP(VFP), .H_BLANK(H_BLANK)
    ) dut (
        .clk(clk),
        .rst(rst),
        .en (en),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Frame buffer returns the low address bits, one clk after the address
    always @(posedge clk) bus.mem_px_data <= 8'(bus.mem_px_addr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_pclk"},  32'(bus.pclk), 32'd0);
        chk({tag, "_vsync"}, 32'(bus.vsync), 32'd0);
        chk({tag, "_href"},  32'(bus.href), 32'd0);
        chk({tag, "_px"},    32'(bus.px_data), 32'd0);
        chk({tag, "_done"},  32'(bus.frame_done), 32'd0);
    endtask

    // Starts one sample after the VSYNC-entry edge; checks every clk of the frame.
    task automatic run_frame(input int stop_at, input int drop_en_at,
                             output int href_pulses, output int vs_ticks);
        logic       exp_vs;
        logic       exp_hr;
        logic [7:0] exp_px;
        int         npx;
        int         ln;
        int         c;
        logic       prev_hr;
        prev_hr     = 1'b0;
        href_pulses = 0;
        vs_ticks    = 0;
        step();
        chk("pclk_first_rise", 32'(bus.pclk), 32'd1);
        chk("done_low_start", 32'(bus.frame_done), 32'd0);
        for (int k = 0; k < FRAME_T; k++) begin
            if (k == drop_en_at) en = 1'b0;
            step();
            exp_vs = (k < VS_END);
            exp_hr = 1'b0;
            exp_px = 8'd0;
            if (k < BP_END) begin
                npx = 0;
            end else if (k < ACT_END) begin
                ln = (k - BP_END) / LINE;
                c  = (k - BP_END) % LINE;
                exp_hr = (c < int'(H_PIX));
                if (exp_hr) exp_px = TP ? 8'(c ^ ln) : 8'((ln * int'(H_PIX) + c) % ADDR_MOD);
                npx = ln * int'(H_PIX) + (exp_hr ? c + 1 : int'(H_PIX));
            end else begin
                npx = int'(V_LINES * H_PIX);
            end
            chk($sformatf("pclk_tick%0d", k), 32'(bus.pclk), 32'd0);
            chk($sformatf("vsync%0d", k), 32'(bus.vsync), 32'(exp_vs));
            chk($sformatf("href%0d", k), 32'(bus.href), 32'(exp_hr));
            chk($sformatf("px%0d", k), 32'(bus.px_data), 32'(exp_px));
            chk($sformatf("done%0d", k), 32'(bus.frame_done), 32'(k == FRAME_T - 1));
            if (k != FRAME_T - 1) begin
                chk($sformatf("addr%0d", k), 32'(bus.mem_px_addr), TP ? 32'd0 : 32'(npx % ADDR_MOD));
            end else if (en) begin
                chk("addr_restart", 32'(bus.mem_px_addr), 32'd0);
            end
            if (bus.vsync === 1'b1) vs_ticks++;
            if (bus.href === 1'b1 && !prev_hr) href_pulses++;
            prev_hr = bus.href;
            if (k == stop_at) return;
            if (k != FRAME_T - 1) begin
                step();
                chk($sformatf("pclk_hi%0d", k), 32'(bus.pclk), 32'd1);
                chk($sformatf("px_hold%0d", k), 32'(bus.px_data), 32'(exp_px));
            end
        end
    endtask

    initial begin
        rst = 1'b0;
        en  = 1'b0;

        // Reset with en low: everything zero, pclk static
        for (int i = 0; i < 5; i++) begin
            step();
            chk_idle("rst");
            chk("rst_addr", 32'(bus.mem_px_addr), 32'd0);
        end

        // Released but disabled: stays idle
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_idle("idle");
        end

        // Frame 1: start from IDLE, pclk still 0 on the entry clk
        en = 1'b1;
        step();
        chk("entry_pclk", 32'(bus.pclk), 32'd0);
        chk("entry_vsync", 32'(bus.vsync), 32'd0);
        run_frame(-1, -1, hp, vt);
        chk("f1_href_pulses", 32'(hp), 32'd5);
        chk("f1_vsync_ticks", 32'(vt), 32'd24);

        // Frame 2: back-to-back, en dropped mid-frame -> completes then idles
        run_frame(-1, 50, hp, vt);
        chk("f2_href_pulses", 32'(hp), 32'd5);
        chk("f2_vsync_ticks", 32'(vt), 32'd24);
        for (int i = 0; i < 4; i++) begin
            step();
            chk_idle("post_drop");
        end

        // Frame 3: reset during active line 3, column 2
        en = 1'b1;
        step();
        chk("f3_entry_pclk", 32'(bus.pclk), 32'd0);
        run_frame(74, -1, hp, vt);
        chk("f3_href_mid", 32'(bus.href), 32'd1);
        chk("f3_px_mid", 32'(bus.px_data), TP ? 32'd1 : 32'd10);
        rst = 1'b0;
        step();
        chk_idle("abort");
        chk("abort_addr", 32'(bus.mem_px_addr), 32'd0);
        step();
        chk_idle("abort_hold");

        // Release with en=1: new frame from vsync and address 0
        rst = 1'b1;
        step();
        chk("f4_entry_pclk", 32'(bus.pclk), 32'd0);
        run_frame(-1, -1, hp, vt);
        chk("f4_href_pulses", 32'(hp), 32'd5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
